// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types, fetch FSM states and bubble constants
package pipeline_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t ins;
        word_t pc_nxt;
        word_t pc;
    } if_id_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t IF_NOP = 32'h0000_0013;

    function automatic if_id_t make_bubble(input word_t nop);
        if_id_t b;
        b.ins    = nop;
        b.pc_nxt = '0;
        b.pc     = '0;
        return b;
    endfunction

    localparam if_id_t IF_ID_BUBBLE = make_bubble(IF_NOP);

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - single-entry holding register for a fetched if_id record
module fetch_skid_buf
    import pipeline_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   unload,
    input  logic   clear,
    input  if_id_t din,
    output logic   valid,
    output if_id_t dout
);

    logic   valid_q, valid_d;
    if_id_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= IF_ID_BUBBLE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, imem request, redirect drain and if_id output
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter word_t NOP_INS = IF_NOP
) (
    input  logic   CLK,
    input  logic   RST,
    output logic   imemREN,
    output word_t  imemaddr,
    input  word_t  imemload,
    input  logic   ihit,
    input  logic   stall,
    input  logic   flush,
    input  logic   redirect,
    input  word_t  redirect_pc,
    input  logic   halt,
    output if_id_t ifid,
    output logic   ifid_valid
);

    localparam if_id_t BUBBLE = make_bubble(NOP_INS);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        target_q, target_d;
    if_id_t       ifid_q, ifid_d;
    logic         ifid_valid_q, ifid_valid_d;

    logic   skid_valid, skid_load, skid_unload, skid_clear;
    if_id_t skid_data;
    if_id_t fetched;
    logic   accept;

    always_comb begin
        imemREN = 1'b0;
        if (!RST) begin
            case (state_q)
                FETCH:   imemREN = !skid_valid;
                DRAIN:   imemREN = 1'b1;
                default: imemREN = 1'b0;
            endcase
        end
    end

    assign imemaddr = pc_q;

    always_comb begin
        fetched.ins    = imemload;
        fetched.pc_nxt = pc_q + 32'd4;
        fetched.pc     = pc_q;
    end

    assign accept = (state_q == FETCH) && imemREN && ihit && !redirect && !flush && !halt;

    // A redirect never moves imemaddr while a request is in flight; DRAIN waits it out.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        if (halt) begin
            state_d = HALTED;
        end else begin
            case (state_q)
                FETCH: begin
                    if (redirect) begin
                        if (imemREN && !ihit) begin
                            target_d = redirect_pc;
                            state_d  = DRAIN;
                        end else begin
                            pc_d = redirect_pc;
                        end
                    end else if (accept) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                DRAIN: begin
                    if (ihit) begin
                        pc_d    = redirect ? redirect_pc : target_q;
                        state_d = FETCH;
                    end else if (redirect) begin
                        target_d = redirect_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ifid_d       = ifid_q;
        ifid_valid_d = ifid_valid_q;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = 1'b0;
        if (halt || flush) begin
            ifid_d       = BUBBLE;
            ifid_valid_d = 1'b0;
            skid_clear   = 1'b1;
        end else if (stall) begin
            skid_load = accept;
        end else if (skid_valid) begin
            ifid_d       = skid_data;
            ifid_valid_d = 1'b1;
            skid_unload  = 1'b1;
        end else if (accept) begin
            ifid_d       = fetched;
            ifid_valid_d = 1'b1;
        end else begin
            ifid_d       = BUBBLE;
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= FETCH;
            pc_q         <= PC_INIT;
            target_q     <= PC_INIT;
            ifid_q       <= BUBBLE;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            ifid_q       <= ifid_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk    (CLK),
        .rst    (RST),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (skid_clear),
        .din    (fetched),
        .valid  (skid_valid),
        .dout   (skid_data)
    );

    assign ifid       = ifid_q;
    assign ifid_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;
    import pipeline_pkg::*;

    logic   CLK = 1'b0;
    logic   RST;
    logic   imemREN;
    word_t  imemaddr;
    word_t  imemload;
    logic   ihit;
    logic   ihit_en;
    logic   stall, flush, redirect, halt;
    word_t  redirect_pc;
    if_id_t ifid;
    logic   ifid_valid;

    int     checks = 0;
    int     errors = 0;
    logic   stall_prev;
    word_t  exp_pc;
    if_id_t exp_rec;
    if_id_t held;
    if_id_t sb[$];

    localparam if_id_t BUB = '{ins: 32'h0000_0013, pc_nxt: 32'h0, pc: 32'h0};

    always #5 CLK = ~CLK;

    function automatic word_t mem_word(input word_t a);
        return 32'h00A0_0093 + (a << 10);
    endfunction

    function automatic if_id_t rec(input word_t pc);
        if_id_t r;
        r.ins    = mem_word(pc);
        r.pc_nxt = pc + 32'd4;
        r.pc     = pc;
        return r;
    endfunction

    assign imemload = mem_word(imemaddr);
    assign ihit     = ihit_en & imemREN;

    fetch_stage #(.PC_INIT(32'h0), .NOP_INS(32'h0000_0013)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .imemload    (imemload),
        .ihit        (ihit),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .ifid        (ifid),
        .ifid_valid  (ifid_valid)
    );

    // ifid is freshly written on any unstalled edge; a valid one must match the scoreboard head.
    task automatic tick();
        stall_prev = stall;
        @(posedge CLK);
        #1;
        if (!RST && !stall_prev && ifid_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %h expected no valid record", ifid);
            end else begin
                exp_rec = sb.pop_front();
                if (ifid !== exp_rec) begin
                    errors++;
                    $display("FAIL sb_record: got %h expected %h", ifid, exp_rec);
                end
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; ihit_en = 1'b0; stall = 1'b0; flush = 1'b0;
        redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        #1;
        checks++;
        if (imemREN !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b expected 0", imemREN); end
        tick();
        tick();
        checks++;
        if (ifid !== BUB || ifid_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ifid: got %h/%b expected %h/0", ifid, ifid_valid, BUB);
        end
        RST = 1'b0;
        #1;
        checks++;
        if (imemREN !== 1'b1 || imemaddr !== 32'h0) begin
            errors++; $display("FAIL reset_fetch: got ren=%b addr=%h expected 1/0", imemREN, imemaddr);
        end
        exp_pc = 32'h0;
    endtask

    task automatic test_sequential();
        ihit_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (imemaddr !== exp_pc) begin errors++; $display("FAIL seq_addr: got %h expected %h", imemaddr, exp_pc); end
            sb.push_back(rec(exp_pc));
            exp_pc = exp_pc + 32'd4;
            tick();
            checks++;
            if (ifid_valid !== 1'b1) begin errors++; $display("FAIL seq_latency: got valid=%b expected 1", ifid_valid); end
        end
    endtask

    task automatic test_stall();
        held = rec(exp_pc - 32'd4);
        stall = 1'b1; ihit_en = 1'b1;
        checks++;
        if (imemaddr !== 32'h8 || imemREN !== 1'b1) begin
            errors++; $display("FAIL stall_req: got addr=%h ren=%b expected 8/1", imemaddr, imemREN);
        end
        sb.push_back(rec(exp_pc));
        exp_pc = exp_pc + 32'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ifid !== held || imemREN !== 1'b0) begin
                errors++; $display("FAIL stall_hold: got ifid=%h ren=%b expected %h/0", ifid, imemREN, held);
            end
        end
        stall = 1'b0; ihit_en = 1'b0;
        tick();
        checks++;
        if (imemREN !== 1'b1 || imemaddr !== 32'hC) begin
            errors++; $display("FAIL stall_resume: got ren=%b addr=%h expected 1/c", imemREN, imemaddr);
        end
        tick();
        checks++;
        if (ifid_valid !== 1'b0) begin errors++; $display("FAIL stall_dup: got valid=%b expected 0", ifid_valid); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL stall_lost: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_redirect_drain();
        ihit_en = 1'b1;
        sb.push_back(rec(exp_pc));
        tick();
        ihit_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h80; flush = 1'b1;
        tick();
        checks++;
        if (imemaddr !== 32'h10 || imemREN !== 1'b1 || ifid_valid !== 1'b0) begin
            errors++; $display("FAIL drain_enter: got addr=%h ren=%b valid=%b expected 10/1/0", imemaddr, imemREN, ifid_valid);
        end
        flush = 1'b0; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        tick();
        checks++;
        if (imemaddr !== 32'h10 || ifid_valid !== 1'b0) begin
            errors++; $display("FAIL drain_hold: got addr=%h valid=%b expected 10/0", imemaddr, ifid_valid);
        end
        ihit_en = 1'b1;
        tick();
        checks++;
        if (imemaddr !== 32'h100 || ifid_valid !== 1'b0) begin
            errors++; $display("FAIL drain_target: got addr=%h valid=%b expected 100/0", imemaddr, ifid_valid);
        end
        exp_pc = 32'h100;
        sb.push_back(rec(exp_pc));
        exp_pc = exp_pc + 32'd4;
        tick();
    endtask

    task automatic test_flush_stall();
        ihit_en = 1'b1; flush = 1'b1; stall = 1'b1;
        tick();
        checks++;
        if (ifid !== BUB || ifid_valid !== 1'b0 || imemREN !== 1'b1 || imemaddr !== exp_pc) begin
            errors++; $display("FAIL flush_stall: got ifid=%h valid=%b ren=%b addr=%h expected %h/0/1/%h",
                               ifid, ifid_valid, imemREN, imemaddr, BUB, exp_pc);
        end
        flush = 1'b0; stall = 1'b0;
        sb.push_back(rec(exp_pc));
        exp_pc = exp_pc + 32'd4;
        tick();
    endtask

    task automatic test_wrap();
        ihit_en = 1'b1; redirect = 1'b1; flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        checks++;
        if (imemaddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redirect: got %h expected fffffffc", imemaddr); end
        redirect = 1'b0; flush = 1'b0;
        sb.push_back(rec(32'hFFFF_FFFC));
        tick();
        checks++;
        if (imemaddr !== 32'h0 || ifid.pc_nxt !== 32'h0) begin
            errors++; $display("FAIL wrap_pc: got addr=%h pc_nxt=%h expected 0/0", imemaddr, ifid.pc_nxt);
        end
    endtask

    task automatic test_halt();
        ihit_en = 1'b0; halt = 1'b1;
        tick();
        halt = 1'b0; ihit_en = 1'b1;
        checks++;
        if (imemREN !== 1'b0 || ifid_valid !== 1'b0) begin
            errors++; $display("FAIL halt_enter: got ren=%b valid=%b expected 0/0", imemREN, ifid_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imemREN !== 1'b0) begin errors++; $display("FAIL halt_stay: got ren=%b expected 0", imemREN); end
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        checks++;
        if (imemREN !== 1'b1 || imemaddr !== 32'h0 || ifid !== BUB) begin
            errors++; $display("FAIL halt_reset: got ren=%b addr=%h ifid=%h expected 1/0/%h", imemREN, imemaddr, ifid, BUB);
        end
        sb.push_back(rec(32'h0));
        tick();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL final_sb: got %0d pending expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drain();
        test_flush_stall();
        test_wrap();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
